cpu_if_ctrl: RTL and testbench
==============================

# cpu_if_ctrl

Parametrised CPU-side bus interface for the accelerator: decodes the CPU address into per-bank SRAM, bias and image write strobes; serves computed results back through a read-valid handshake; and adds a control/status page that starts the compute core, tracks completion and raises an interrupt. It sits between the host CPU bus and the SRAM bank array / compute core, and replaces the fixed 46-bank interface with a generic one.

## Interface
- N_SRAM, 46, number of weight SRAM banks; must be ≤ BIAS_PAGE
- N_RESULT, 46, number of readable result words
- ADR_W, 18, CPU byte-address width
- DATA_W, 32, data width
- PAGE_BITS, 12, offset bits per page; page = CPU_ADR[ADR_W-1:PAGE_BITS]
- BIAS_PAGE, 6'h2E; IMAGE_PAGE, 6'h30; RESULT_PAGE, 6'h31; CTRL_PAGE, 6'h32: page numbers

Ports:
- CLK  in  1  clock
- RESET_X  in  1  asynchronous active-low reset
- CPU_WR  in  1  write strobe, one write per high cycle
- CPU_RD  in  1  read strobe, one read per high cycle
- CPU_ADR  in  ADR_W  byte address
- CPU_WDATA  in  DATA_W  write data
- CPU_RDATA  out  DATA_W  read data, valid with CPU_RVALID
- CPU_RVALID  out  1  read-data-valid pulse
- SRAM_SEL  out  N_SRAM  one-hot bank write select
- BIAS_SEL, IMAGE_SEL  out  1 each  bias / image buffer write select
- SRAM_BIAS_IMG_WR  out  1  write strobe to SRAM/bias/image
- SRAM_ADR  out  PAGE_BITS-2  word offset within page
- SRAM_DATA  out  DATA_W  write data
- RESULT  in  N_RESULT*DATA_W  result k at [k*DATA_W +: DATA_W]
- CORE_START  out  1  one-cycle start pulse to compute core
- CORE_DONE  in  1  one-cycle completion pulse from core
- IRQ  out  1  level interrupt

## Operation
- Reset: every output 0; state IDLE; IRQ_EN, DONE, WR_BLK cleared.
- Write path: CPU_WR with page < N_SRAM, = BIAS_PAGE or = IMAGE_PAGE registers the matching select, SRAM_BIAS_IMG_WR=1, SRAM_ADR=CPU_ADR[PAGE_BITS-1:2], SRAM_DATA=CPU_WDATA. Selects asserted only with the write strobe; otherwise all selects 0.
- Write to any other page except CTRL_PAGE: no strobe, dropped.
- Write blocking: data-page write while state RUN is suppressed (no strobe) and sets sticky WR_BLK.
- Read path: CPU_RD on RESULT_PAGE returns RESULT[idx], idx=CPU_ADR[PAGE_BITS-1:2]; idx ≥ N_RESULT returns 0. CTRL_PAGE reads per register map. Any other page returns 0. CPU_RVALID pulses for every accepted read.
- CPU_WR and CPU_RD same cycle: write performed, read ignored (no CPU_RVALID).
- CTRL_PAGE map (offset): 0x0 CTRL, W bit0 START (self-clearing, reads 0), RW bit1 IRQ_EN; 0x4 STATUS, R bit0 BUSY, bit1 DONE, bit2 WR_BLK; write-1-to-clear on bits1,2.
- FSM: IDLE -START-> RUN (CORE_START pulse, DONE cleared); RUN -CORE_DONE-> IDLE, DONE set. START in RUN ignored; CORE_DONE in IDLE ignored. BUSY = (state==RUN).
- STATUS W1C of DONE in same cycle as CORE_DONE: set wins.
- IRQ = DONE & IRQ_EN.
- Reset asserted mid-RUN: immediately IDLE, all flags and outputs 0; late CORE_DONE after reset ignored.

## Timing
- All outputs registered; write-path outputs valid cycle N+1 for strobe in cycle N, held exactly one cycle per strobe cycle; back-to-back writes give continuous strobe.
- Read latency 1: CPU_RDATA/CPU_RVALID in cycle N+1; CPU_RDATA holds last read value until next read.
- CORE_START in cycle N+1 after START write in cycle N; BUSY reads 1 from cycle N+1.
- DONE/IRQ set cycle N+1 after CORE_DONE in cycle N; BUSY 0 same cycle.

## Configuration
- CPU_IF_IRQ_EN defined: IRQ_EN bit and IRQ output as above.
- Not defined: IRQ tied 0, IRQ_EN bit not implemented (writes ignored, reads 0); DONE still polls via STATUS.

## Test plan
- Reset then write 0xDEADBEEF to 0x05010 -> cycle+1 SRAM_SEL=1<<5, SRAM_ADR=4, SRAM_DATA=0xDEADBEEF, WR=1 for one cycle; write to 0x2F000 -> no strobe.
- RESULT[3]=0x12345678; read 0x3100C -> next cycle RDATA=0x12345678, RVALID=1; read 0x310B8 (idx 46) -> RDATA=0.
- Write CTRL=0x3 -> CORE_START pulse, STATUS=0x1; CORE_DONE pulse -> STATUS=0x2, IRQ=1; write STATUS=0x2 -> DONE=0, IRQ=0.
- During RUN write 0x00000 -> no SRAM_BIAS_IMG_WR, STATUS bit2=1; second START ignored (no CORE_START).
- CPU_WR and CPU_RD together at 0x31000 -> no RVALID; RESET_X low mid-RUN -> all outputs 0, STATUS=0.

Source files
------------

// File: rtl/cpu_if_ctrl.sv
// cpu_if_ctrl: CPU bus interface for the accelerator.
// Decodes CPU writes into per-bank SRAM / bias / image write strobes.
// Serves result words and control/status reads with a one-cycle read-valid.
// Runs the compute-core start/done handshake.
// Optional feature macro: CPU_IF_IRQ_EN (IRQ_EN control bit and IRQ output).
module cpu_if_ctrl #(
  parameter int unsigned N_SRAM      = 46,
  parameter int unsigned N_RESULT    = 46,
  parameter int unsigned ADR_W       = 18,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PAGE_BITS   = 12,
  parameter int unsigned BIAS_PAGE   = 'h2E,
  parameter int unsigned IMAGE_PAGE  = 'h30,
  parameter int unsigned RESULT_PAGE = 'h31,
  parameter int unsigned CTRL_PAGE   = 'h32
) (
  input  logic                         CLK,
  input  logic                         RESET_X,
  input  logic                         CPU_WR,
  input  logic                         CPU_RD,
  input  logic [ADR_W-1:0]             CPU_ADR,
  input  logic [DATA_W-1:0]            CPU_WDATA,
  output logic [DATA_W-1:0]            CPU_RDATA,
  output logic                         CPU_RVALID,
  output logic [N_SRAM-1:0]            SRAM_SEL,
  output logic                         BIAS_SEL,
  output logic                         IMAGE_SEL,
  output logic                         SRAM_BIAS_IMG_WR,
  output logic [PAGE_BITS-3:0]         SRAM_ADR,
  output logic [DATA_W-1:0]            SRAM_DATA,
  input  logic [N_RESULT*DATA_W-1:0]   RESULT,
  output logic                         CORE_START,
  input  logic                         CORE_DONE,
  output logic                         IRQ
);

  localparam int unsigned PG_W  = ADR_W - PAGE_BITS;
  localparam int unsigned OFF_W = PAGE_BITS - 2;

  // Word offsets inside the control page
  localparam logic [OFF_W-1:0] CTRL_OFF   = OFF_W'(0);
  localparam logic [OFF_W-1:0] STATUS_OFF = OFF_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic                  wr_blk_q, wr_blk_d;
  logic [N_SRAM-1:0]     sram_sel_q, sram_sel_d;
  logic                  bias_sel_q, bias_sel_d;
  logic                  image_sel_q, image_sel_d;
  logic                  wr_q, wr_d;
  logic [OFF_W-1:0]      adr_q, adr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  start_q, start_d;
`ifdef CPU_IF_IRQ_EN
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
`endif

  logic [PG_W-1:0]       page_c;
  logic [OFF_W-1:0]      off_c;
  logic                  data_page_c;
  logic                  unused_adr_c;

  // Address split into page number and word offset
  assign page_c       = CPU_ADR[ADR_W-1:PAGE_BITS];
  assign off_c        = CPU_ADR[PAGE_BITS-1:2];
  assign unused_adr_c = ^CPU_ADR[1:0];
  assign data_page_c  = (page_c < PG_W'(N_SRAM))  ||
                        (page_c == PG_W'(BIAS_PAGE)) ||
                        (page_c == PG_W'(IMAGE_PAGE));

  // State and all registered outputs
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      wr_blk_q    <= 1'b0;
      sram_sel_q  <= '0;
      bias_sel_q  <= 1'b0;
      image_sel_q <= 1'b0;
      wr_q        <= 1'b0;
      adr_q       <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      start_q     <= 1'b0;
`ifdef CPU_IF_IRQ_EN
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      wr_blk_q    <= wr_blk_d;
      sram_sel_q  <= sram_sel_d;
      bias_sel_q  <= bias_sel_d;
      image_sel_q <= image_sel_d;
      wr_q        <= wr_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      start_q     <= start_d;
`ifdef CPU_IF_IRQ_EN
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
`endif
    end
  end

  // Next state: write decode, control page, core handshake, read mux
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    wr_blk_d    = wr_blk_q;
    sram_sel_d  = '0;
    bias_sel_d  = 1'b0;
    image_sel_d = 1'b0;
    wr_d        = 1'b0;
    adr_d       = adr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    start_d     = 1'b0;
`ifdef CPU_IF_IRQ_EN
    irq_en_d    = irq_en_q;
    irq_d       = 1'b0;
`endif

    // Data-page writes; blocked and flagged while the core is running
    if (CPU_WR && data_page_c) begin
      if (state_q == RUN) begin
        wr_blk_d = 1'b1;
      end else begin
        wr_d        = 1'b1;
        adr_d       = off_c;
        data_d      = CPU_WDATA;
        bias_sel_d  = (page_c == PG_W'(BIAS_PAGE));
        image_sel_d = (page_c == PG_W'(IMAGE_PAGE));
        for (int k = 0; k < int'(N_SRAM); k++) begin
          sram_sel_d[k] = (page_c == PG_W'(k));
        end
      end
    end

    // Control page writes
    if (CPU_WR && (page_c == PG_W'(CTRL_PAGE))) begin
      if (off_c == CTRL_OFF) begin
        if (CPU_WDATA[0] && (state_q == IDLE)) begin
          state_d = RUN;
          start_d = 1'b1;
          done_d  = 1'b0;
        end
`ifdef CPU_IF_IRQ_EN
        irq_en_d = CPU_WDATA[1];
`endif
      end else if (off_c == STATUS_OFF) begin
        if (CPU_WDATA[1]) done_d   = 1'b0;
        if (CPU_WDATA[2]) wr_blk_d = 1'b0;
      end
    end

    // Core completion; evaluated after W1C so a simultaneous set wins
    if (CORE_DONE && (state_q == RUN)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end

    // Reads are accepted only when no write shares the cycle
    if (CPU_RD && !CPU_WR) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      if (page_c == PG_W'(RESULT_PAGE)) begin
        for (int k = 0; k < int'(N_RESULT); k++) begin
          if (off_c == OFF_W'(k)) rdata_d = RESULT[k*DATA_W +: DATA_W];
        end
      end else if (page_c == PG_W'(CTRL_PAGE)) begin
        if (off_c == CTRL_OFF) begin
`ifdef CPU_IF_IRQ_EN
          rdata_d = DATA_W'({irq_en_q, 1'b0});
`endif
        end else if (off_c == STATUS_OFF) begin
          rdata_d = DATA_W'({wr_blk_q, done_q, (state_q == RUN)});
        end
      end
    end

`ifdef CPU_IF_IRQ_EN
    irq_d = done_d & irq_en_d;
`endif
  end

  assign CPU_RDATA        = rdata_q;
  assign CPU_RVALID       = rvalid_q;
  assign SRAM_SEL         = sram_sel_q;
  assign BIAS_SEL         = bias_sel_q;
  assign IMAGE_SEL        = image_sel_q;
  assign SRAM_BIAS_IMG_WR = wr_q;
  assign SRAM_ADR         = adr_q;
  assign SRAM_DATA        = data_q;
  assign CORE_START       = start_q;
`ifdef CPU_IF_IRQ_EN
  assign IRQ              = irq_q;
`else
  assign IRQ              = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_if_ctrl.sv
// tb_cpu_if_ctrl: directed plus randomized checks of cpu_if_ctrl against a
// transaction-level model of the CPU-visible behaviour.
module tb_cpu_if_ctrl;

  localparam int unsigned NS = 46;
  localparam int unsigned NR = 46;

  logic             clk;
  logic             rst_x;
  logic             cpu_wr, cpu_rd;
  logic [17:0]      cpu_adr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_rvalid;
  logic [NS-1:0]    sram_sel;
  logic             bias_sel, image_sel, sbi_wr;
  logic [9:0]       sram_adr;
  logic [31:0]      sram_data;
  logic [NR*32-1:0] result;
  logic             core_start, core_done, irq;

  int n_checks = 0;
  int n_errors = 0;

  // Model state (CPU-visible meaning, not RTL encoding)
  bit          m_busy, m_done, m_irq_en, m_wr_blk;
  logic [63:0] e_sel;
  bit          e_bias, e_img, e_wr, e_start, e_rvalid, e_irq;
  logic [9:0]  e_adr;
  logic [31:0] e_data, e_rdata;

  cpu_if_ctrl dut (
    .CLK              (clk),
    .RESET_X          (rst_x),
    .CPU_WR           (cpu_wr),
    .CPU_RD           (cpu_rd),
    .CPU_ADR          (cpu_adr),
    .CPU_WDATA        (cpu_wdata),
    .CPU_RDATA        (cpu_rdata),
    .CPU_RVALID       (cpu_rvalid),
    .SRAM_SEL         (sram_sel),
    .BIAS_SEL         (bias_sel),
    .IMAGE_SEL        (image_sel),
    .SRAM_BIAS_IMG_WR (sbi_wr),
    .SRAM_ADR         (sram_adr),
    .SRAM_DATA        (sram_data),
    .RESULT           (result),
    .CORE_START       (core_start),
    .CORE_DONE        (core_done),
    .IRQ              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_irq_en = 0; m_wr_blk = 0;
    e_sel = 0; e_bias = 0; e_img = 0; e_wr = 0; e_start = 0;
    e_rvalid = 0; e_irq = 0; e_adr = 0; e_data = 0; e_rdata = 0;
  endtask

  // Expected outputs one cycle after the given bus/core inputs
  task automatic model(input bit wr, input bit rd, input logic [17:0] adr,
                       input logic [31:0] wd, input bit cd);
    int page;
    int idx;
    bit data_page;
    bit n_busy, n_done, n_wr_blk;
    page = int'(adr >> 12);
    idx  = int'((adr & 18'hFFF) >> 2);
    data_page = (page < 46) || (page == 'h2E) || (page == 'h30);
    n_busy = m_busy; n_done = m_done; n_wr_blk = m_wr_blk;
    e_sel = 0; e_bias = 0; e_img = 0; e_wr = 0; e_start = 0; e_rvalid = 0;

    if (rd && !wr) begin
      e_rvalid = 1;
      e_rdata  = 0;
      if (page == 'h31 && idx < 46) e_rdata = result[idx*32 +: 32];
      if (page == 'h32 && idx == 0) e_rdata = {30'd0, m_irq_en, 1'b0};
      if (page == 'h32 && idx == 1) e_rdata = {29'd0, m_wr_blk, m_done, m_busy};
    end

    if (wr && data_page) begin
      if (m_busy) n_wr_blk = 1;
      else begin
        e_wr = 1; e_adr = 10'(idx); e_data = wd;
        if (page < 46) e_sel = 64'd1 << page;
        e_bias = (page == 'h2E);
        e_img  = (page == 'h30);
      end
    end

    if (wr && page == 'h32 && idx == 0) begin
      if (wd[0] && !m_busy) begin
        e_start = 1; n_busy = 1; n_done = 0;
      end
`ifdef CPU_IF_IRQ_EN
      m_irq_en = wd[1];
`endif
    end
    if (wr && page == 'h32 && idx == 1) begin
      if (wd[1]) n_done = 0;
      if (wd[2]) n_wr_blk = 0;
    end

    if (cd && m_busy) begin
      n_busy = 0; n_done = 1;
    end

    m_busy = n_busy; m_done = n_done; m_wr_blk = n_wr_blk;
    e_irq = m_done & m_irq_en;
  endtask

  task automatic compare(input string pfx);
    check({pfx, ".sel"},    64'(sram_sel),   e_sel);
    check({pfx, ".bias"},   64'(bias_sel),   64'(e_bias));
    check({pfx, ".img"},    64'(image_sel),  64'(e_img));
    check({pfx, ".wr"},     64'(sbi_wr),     64'(e_wr));
    check({pfx, ".start"},  64'(core_start), 64'(e_start));
    check({pfx, ".rvalid"}, 64'(cpu_rvalid), 64'(e_rvalid));
    check({pfx, ".rdata"},  64'(cpu_rdata),  64'(e_rdata));
    check({pfx, ".irq"},    64'(irq),        64'(e_irq));
    if (e_wr) begin
      check({pfx, ".adr"},  64'(sram_adr),   64'(e_adr));
      check({pfx, ".data"}, 64'(sram_data),  64'(e_data));
    end
  endtask

  // One bus cycle: drive at negedge, DUT samples at posedge, check at next negedge
  task automatic step(input string tag, input bit wr, input bit rd, input logic [17:0] adr,
                      input logic [31:0] wd, input bit cd);
    cpu_wr = wr; cpu_rd = rd; cpu_adr = adr; cpu_wdata = wd; core_done = cd;
    model(wr, rd, adr, wd, cd);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 18'h0, 32'h0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sel"},    64'(sram_sel),   64'd0);
    check({tag, ".bias"},   64'(bias_sel),   64'd0);
    check({tag, ".img"},    64'(image_sel),  64'd0);
    check({tag, ".wr"},     64'(sbi_wr),     64'd0);
    check({tag, ".adr"},    64'(sram_adr),   64'd0);
    check({tag, ".data"},   64'(sram_data),  64'd0);
    check({tag, ".rdata"},  64'(cpu_rdata),  64'd0);
    check({tag, ".rvalid"}, 64'(cpu_rvalid), 64'd0);
    check({tag, ".start"},  64'(core_start), 64'd0);
    check({tag, ".irq"},    64'(irq),        64'd0);
  endtask

  initial begin
    logic [5:0]  pg;
    logic [9:0]  ix;
    logic [17:0] a;
    bit          irq_exp;
`ifdef CPU_IF_IRQ_EN
    irq_exp = 1;
`else
    irq_exp = 0;
`endif
    rst_x = 0; cpu_wr = 0; cpu_rd = 0; cpu_adr = 0; cpu_wdata = 0; core_done = 0;
    for (int k = 0; k < int'(NR); k++) result[k*32 +: 32] = $urandom;
    result[3*32 +: 32] = 32'h12345678;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_x = 1;
    idle("post_reset");

    // Write path
    step("wr_bank5", 1, 0, 18'h05010, 32'hDEADBEEF, 0);
    check("tp_sel5", 64'(sram_sel), 64'd1 << 5);
    check("tp_adr4", 64'(sram_adr), 64'd4);
    check("tp_data", 64'(sram_data), 64'hDEADBEEF);
    idle("wr_drop");
    check("tp_wr_one_cycle", 64'(sbi_wr), 64'd0);
    step("wr_unmapped", 1, 0, 18'h2F000, 32'h11111111, 0);
    check("tp_unmapped", 64'(sbi_wr), 64'd0);
    step("wr_bias", 1, 0, 18'h2E008, 32'hA5A5A5A5, 0);
    step("wr_img", 1, 0, 18'h30FFC, 32'h5A5A5A5A, 0);
    step("wr_b2b", 1, 0, 18'h2D004, 32'h01020304, 0);

    // Read path
    step("rd_res3", 0, 1, 18'h3100C, 32'h0, 0);
    check("tp_res3", 64'(cpu_rdata), 64'h12345678);
    check("tp_rvalid", 64'(cpu_rvalid), 64'd1);
    step("rd_res46", 0, 1, 18'h310B8, 32'h0, 0);
    check("tp_res46", 64'(cpu_rdata), 64'd0);
    idle("rd_hold");

    // Start / done / irq
    step("start", 1, 0, 18'h32000, 32'h3, 0);
    check("tp_start", 64'(core_start), 64'd1);
    step("rd_status_busy", 0, 1, 18'h32004, 32'h0, 0);
    check("tp_status_busy", 64'(cpu_rdata), 64'h1);
    idle("run_wait");
    step("core_done", 0, 0, 18'h0, 32'h0, 1);
    check("tp_irq_set", 64'(irq), 64'(irq_exp));
    step("rd_status_done", 0, 1, 18'h32004, 32'h0, 0);
    check("tp_status_done", 64'(cpu_rdata), 64'h2);
    step("w1c_done", 1, 0, 18'h32004, 32'h2, 0);
    check("tp_irq_clr", 64'(irq), 64'd0);
    step("rd_status_clr", 0, 1, 18'h32004, 32'h0, 0);
    check("tp_status_clr", 64'(cpu_rdata), 64'h0);

    // Write blocking and ignored second START
    step("start2", 1, 0, 18'h32000, 32'h1, 0);
    step("wr_blocked", 1, 0, 18'h00000, 32'hCAFEF00D, 0);
    check("tp_blocked", 64'(sbi_wr), 64'd0);
    step("start_in_run", 1, 0, 18'h32000, 32'h1, 0);
    check("tp_no_restart", 64'(core_start), 64'd0);
    step("rd_status_blk", 0, 1, 18'h32004, 32'h0, 0);
    check("tp_status_blk", 64'(cpu_rdata), 64'h5);
    step("done_w1c_race", 1, 0, 18'h32004, 32'h6, 1);
    step("rd_status_race", 0, 1, 18'h32004, 32'h0, 0);
    check("tp_set_wins", 64'(cpu_rdata), 64'h2);

    // Simultaneous write and read
    step("wr_rd_same", 1, 1, 18'h31000, 32'h0, 0);
    check("tp_no_rvalid", 64'(cpu_rvalid), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: pg = 6'($urandom_range(0, 45));
        1: pg = 6'h2E;
        2: pg = 6'h30;
        3: pg = 6'h31;
        4: pg = 6'h32;
        default: pg = 6'($urandom_range(0, 63));
      endcase
      if (pg == 6'h32)      ix = 10'($urandom_range(0, 2));
      else if (pg == 6'h31) ix = 10'($urandom_range(0, 50));
      else                  ix = 10'($urandom_range(0, 1023));
      a = {pg, ix, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0)
        result[$urandom_range(0, NR-1)*32 +: 32] = $urandom;
      step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, $urandom,
           $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a run
    step("w1c_all", 1, 0, 18'h32004, 32'h6, 0);
    step("start_rst", 1, 0, 18'h32000, 32'h3, 0);
    idle("run_before_rst");
    #2 rst_x = 0;
    #1 model_reset();
    check_all_zero("mid_run_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    rst_x = 1;
    step("late_done", 0, 0, 18'h0, 32'h0, 1);
    check("tp_late_done_start", 64'(core_start), 64'd0);
    step("rd_status_after_rst", 0, 1, 18'h32004, 32'h0, 0);
    check("tp_status_rst", 64'(cpu_rdata), 64'h0);
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
